m2s_adapter: RTL
================

Name: m2s_adapter

Overview:
- Upstream feeder of the cipher core: reads source data from memory over an Avalon-MM burst read master and presents it as a 512-bit Avalon-ST source stream.
- Mirror of the stream-to-memory writer at the core output.
- Configured by CPU through a 4-register CSR slave; raises irq once the programmed number of 512-bit blocks has been delivered downstream.

Parameters:
- FIFO_DEPTH, 4, number of 512-bit entries in the output buffer; also bounds outstanding bursts; power of 2, >= 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- csr_write  in  1  CSR write strobe
- csr_read  in  1  CSR read strobe
- csr_address  in  2  CSR word address
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered
- m_read  out  1  Avalon-MM burst read request
- m_address  out  32  byte address of current burst
- m_burstcount  out  2  constant 2
- m_waitrequest  in  1  slave stall
- m_readdata  in  256  read beat data
- m_readdatavalid  in  1  read beat valid
- src_data  out  512  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready
- irq  out  1  completion interrupt, level

Behaviour:
- CSR map:
  - 0 LEN: number of 512-bit blocks. Write with nonzero value starts a job; zero is ignored.
  - 1 ADDR: start byte address, 64-byte aligned; bits [5:0] are forced to 0.
  - 2 STATUS: read {30'b0, busy, irq}; any write clears irq.
  - 3 REMAIN: read-only; blocks not yet delivered.
- csr_readdata updates the cycle after csr_read. Unread cycles hold the previous value. Reset value 0.
- Writes to LEN or ADDR while busy are ignored. STATUS writes always act.
- Reset values: m_read=0, m_address=0, src_valid=0, irq=0, busy=0, all counters=0, FIFO empty.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on valid LEN write: busy=1, req_left=LEN, remain=LEN.
  - RUN -> DRAIN when req_left reaches 0 (all bursts accepted).
  - DRAIN -> IDLE when remain reaches 0: busy=0, irq=1 in the same cycle.
- Request issue:
  - m_read asserted in RUN when req_left>0 and (fifo_count + outstanding) < FIFO_DEPTH.
  - Once asserted, m_read, m_address and m_burstcount are held stable while m_waitrequest=1.
  - Acceptance = m_read && !m_waitrequest. On acceptance: req_left -1, outstanding +1, m_address +64.
  - m_read may stay asserted back-to-back if the credit condition still holds after acceptance.
- Response packing:
  - First beat of a burst is stored into [255:0], second into [511:256].
  - Second beat pushes the 512-bit word into the FIFO and decrements outstanding.
  - Beat parity toggle resets to "low" at job start.
- m_readdatavalid with outstanding=0 is ignored, e.g. a stale response after reset.
- FIFO can never overflow, by the credit rule. An assertion flags push-while-full.
- Stream: src_valid = FIFO not empty; src_data = FIFO head, valid in the same cycle.
- Transfer = src_valid && src_ready. It pops the FIFO and decrements remain.
- Push and pop in the same cycle leave fifo_count unchanged. Acceptance and second beat in the same cycle leave outstanding unchanged.
- Latency: first src_valid no earlier than 1 cycle after the second beat of burst 0.
- irq stays 1 until a STATUS write. A STATUS write in the same cycle as completion leaves irq=1 (set wins).
- Counter widths: req_left and remain 32-bit; outstanding and fifo_count clog2(FIFO_DEPTH)+1 bits. Address wraps modulo 2^32.
- Reset mid-job: everything returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package m2s_pkg: CsrAddr_t (2-bit), Word_t (32), MasterData_t (256), StreamData_t (512), CSR address constants LEN/ADDR/STATUS/REMAIN, BURST_BYTES=64.
- One sub-module: sync_fifo.
  - Parameters: WIDTH=512, DEPTH=FIFO_DEPTH.
  - Show-ahead read; outputs count, full, empty.

Test Plan:
- ADDR=0x1000, LEN=1, slave returns beats A then B with no stalls -> one burst at 0x1000, burstcount=2; src_data={B,A}; src_valid pulses once; irq=1; STATUS reads 0x1.
- LEN=8, src_ready=0 throughout -> exactly 4 bursts issued (0x1000..0x10C0), then m_read=0. Release src_ready -> remaining 4 bursts at 0x1100..0x11C0; 8 blocks delivered in order; irq after the 8th.
- m_waitrequest high for 5 cycles on the first request -> m_read and m_address=0x1000 held stable for all 5 cycles; single acceptance; no duplicate burst.
- LEN write while busy with value 3 during a LEN=2 job -> ignored; exactly 2 blocks delivered; REMAIN reads 2,1,0 across the job.
- Reset asserted after 1 of 3 bursts accepted, then a late m_readdatavalid beat arrives -> beat ignored; src_valid=0, busy=0, irq=0, m_read=0.
- irq set, then STATUS write of 0 -> irq=0. A STATUS write in the same cycle as job completion -> irq remains 1.

Source files
------------

// File: rtl/m2s_pkg.sv
// Shared types and CSR constants for the memory-to-stream adapter.
package m2s_pkg;
  typedef logic [1:0]   CsrAddr_t;
  typedef logic [31:0]  Word_t;
  typedef logic [255:0] MasterData_t;
  typedef logic [511:0] StreamData_t;

  localparam CsrAddr_t CSR_LEN    = 2'd0;
  localparam CsrAddr_t CSR_ADDR   = 2'd1;
  localparam CsrAddr_t CSR_STATUS = 2'd2;
  localparam CsrAddr_t CSR_REMAIN = 2'd3;

  localparam Word_t BURST_BYTES = 32'd64;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  function automatic Word_t align_addr(input Word_t a);
    return a & ~(BURST_BYTES - 32'd1);
  endfunction
endpackage

// File: rtl/m2s_adapter_sync_fifo.sv
// Show-ahead synchronous FIFO: head is valid combinationally while not empty.
// Pushing when full is a caller error and is flagged by an assertion.
module sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && full));
  end
endmodule

// File: rtl/m2s_adapter.sv
// Burst-reads 64-byte blocks from memory and streams them out as 512-bit words.
// First block appears 1 cycle after its second beat; requests stall on FIFO credit.
module m2s_adapter
  import m2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_write,
  input  logic        csr_read,
  input  CsrAddr_t    csr_address,
  input  Word_t       csr_writedata,
  output Word_t       csr_readdata,
  output logic        m_read,
  output Word_t       m_address,
  output logic [1:0]  m_burstcount,
  input  logic        m_waitrequest,
  input  MasterData_t m_readdata,
  input  logic        m_readdatavalid,
  output StreamData_t src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q;
  Word_t         req_left_q, req_left_d, remain_q, len_q, addr_q, rdata_q;
  logic [CW-1:0] outst_q, outst_d, fifo_count, fifo_count_d;
  logic [CW:0]   credit_d;
  logic          m_read_q, m_read_d, beat_hi_q, irq_q, run_d;
  logic          accept, beat_ok, push, pop, start, done, fifo_full, fifo_empty;
  MasterData_t   lo_q;
  StreamData_t   fifo_head;

  assign accept  = m_read_q && !m_waitrequest;
  assign beat_ok = m_readdatavalid && (outst_q != '0);
  assign push    = beat_ok && beat_hi_q;
  assign pop     = !fifo_empty && src_ready;
  assign start   = csr_write && (csr_address == CSR_LEN) && (state_q == ST_IDLE)
                   && (csr_writedata != '0);
  assign done    = pop && (state_q == ST_DRAIN) && (remain_q == 32'd1);

  // Credit counts both buffered words and bursts still in flight.
  always_comb begin
    outst_d = outst_q;
    if (accept && !push)      outst_d = outst_q + CW'(1);
    else if (!accept && push) outst_d = outst_q - CW'(1);
    fifo_count_d = fifo_count;
    if (push && !pop)         fifo_count_d = fifo_count + CW'(1);
    else if (!push && pop)    fifo_count_d = fifo_count - CW'(1);
    req_left_d = req_left_q;
    if (start)                req_left_d = csr_writedata;
    else if (accept)          req_left_d = req_left_q - 32'd1;
    run_d    = start || ((state_q == ST_RUN) && !(accept && (req_left_q == 32'd1)));
    credit_d = {1'b0, fifo_count_d} + {1'b0, outst_d};
    m_read_d = (m_read_q && m_waitrequest)
               || (run_d && (req_left_d != '0) && (credit_d < (CW+1)'(FIFO_DEPTH)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_left_q <= '0;
      remain_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      outst_q    <= '0;
      m_read_q   <= 1'b0;
      beat_hi_q  <= 1'b0;
      irq_q      <= 1'b0;
      lo_q       <= '0;
    end else begin
      m_read_q   <= m_read_d;
      outst_q    <= outst_d;
      req_left_q <= req_left_d;

      if (accept)
        addr_q <= addr_q + BURST_BYTES;
      else if (csr_write && (csr_address == CSR_ADDR) && (state_q == ST_IDLE))
        addr_q <= align_addr(csr_writedata);

      if (beat_ok) begin
        if (!beat_hi_q) lo_q <= m_readdata;
        beat_hi_q <= !beat_hi_q;
      end
      if (start) beat_hi_q <= 1'b0;

      if (start)                         remain_q <= csr_writedata;
      else if (pop && (remain_q != '0))  remain_q <= remain_q - 32'd1;

      case (state_q)
        ST_IDLE:  if (start) begin
                    state_q <= ST_RUN;
                    len_q   <= csr_writedata;
                  end
        ST_RUN:   if (accept && (req_left_q == 32'd1)) state_q <= ST_DRAIN;
        ST_DRAIN: if (done) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      // Completion wins over a simultaneous STATUS clear.
      if (done)                                          irq_q <= 1'b1;
      else if (csr_write && (csr_address == CSR_STATUS)) irq_q <= 1'b0;

      if (csr_read) begin
        case (csr_address)
          CSR_LEN:    rdata_q <= len_q;
          CSR_ADDR:   rdata_q <= addr_q;
          CSR_STATUS: rdata_q <= {30'b0, state_q != ST_IDLE, irq_q};
          default:    rdata_q <= remain_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(fifo_full && (outst_q != '0)));
  end

  sync_fifo #(.WIDTH(512), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({m_readdata, lo_q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign csr_readdata = rdata_q;
  assign m_read       = m_read_q;
  assign m_address    = addr_q;
  assign m_burstcount = 2'd2;
  assign src_data     = fifo_head;
  assign src_valid    = !fifo_empty;
  assign irq          = irq_q;
endmodule
